// File: rtl/dac_wave_pkg.sv
// Shared types and default widths for the DAC waveform sequencer.
package dac_wave_pkg;

  localparam int DAC_W_DEF = 8;
  localparam int DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_TRI    = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_HOLD   = 2'd3
  } wave_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/dac_tick_div.sv
// Sample-period divider: counts 0..div_reg, flags the last cycle of each
// period (tick) and produces the DAC latch clock, high in the second half.
module dac_tick_div
  import dac_wave_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_reg_i,
  output logic             tick_o,
  output logic             dac_clk_o
);

  logic [DIV_W-1:0] div_cnt_q;
  logic             dac_clk_q;

  assign tick_o    = en_i && (div_cnt_q == div_reg_i);
  assign dac_clk_o = dac_clk_q;

  // Period counter and latch clock; both held at zero while disabled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      dac_clk_q <= 1'b0;
    end else if (!en_i) begin
      div_cnt_q <= '0;
      dac_clk_q <= 1'b0;
    end else if (tick_o) begin
      div_cnt_q <= '0;
      dac_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
      if (div_cnt_q == (div_reg_i >> 1)) begin
        dac_clk_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac_wave_sched.sv
// Waveform sequencer: accepts run/stop commands, holds at most one pending
// command, and applies it only on a sample-period boundary (tick).
module dac_wave_sched
  import dac_wave_pkg::*;
#(
  parameter int DAC_W = DAC_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_run,
  input  logic [1:0]       cfg_wave,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DAC_W-1:0] cfg_step,
  output logic [DAC_W-1:0] dac_data,
  output logic             dac_clk,
  output logic             sample_stb,
  output logic             busy
);

  typedef struct packed {
    logic             run;
    wave_e            wave;
    logic [DIV_W-1:0] div;
    logic [DAC_W-1:0] step;
  } cmd_t;

  localparam logic [DAC_W-1:0] ACC_MAX     = {DAC_W{1'b1}};
  localparam logic [DAC_W:0]   ACC_MAX_EXT = {1'b0, ACC_MAX};
  localparam logic [DIV_W-1:0] DIV_ONE     = {{(DIV_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  wave_e            wave_q;
  logic [DAC_W-1:0] step_q;
  logic [DIV_W-1:0] div_q;
  logic [DAC_W-1:0] acc_q;
  dir_e             dir_q;
  logic [DAC_W-1:0] dac_data_q;
  logic             sample_stb_q;
  logic             pend_full_q;
  cmd_t             pend_q;

  cmd_t             cmd_in;
  logic             hs;
  logic             tick;
  logic             apply_run;
  logic             apply_stop;
  logic             restart;
  wave_e            wave_sel;
  logic [DAC_W-1:0] step_sel;
  logic [DAC_W:0]   sum;
  logic [DAC_W-1:0] acc_d;
  dir_e             dir_d;
  logic [DAC_W-1:0] data_d;

  assign cfg_ready  = !pend_full_q;
  assign hs         = cfg_valid && cfg_ready;
  assign dac_data   = dac_data_q;
  assign sample_stb = sample_stb_q;
  assign busy       = (state_q == ST_RUN);

  dac_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .en_i      (state_q == ST_RUN),
    .div_reg_i (div_q),
    .tick_o    (tick),
    .dac_clk_o (dac_clk)
  );

  // Incoming command, with a zero divider promoted to one.
  always_comb begin
    cmd_in.run  = cfg_run;
    cmd_in.wave = wave_e'(cfg_wave);
    cmd_in.div  = (cfg_div == '0) ? DIV_ONE : cfg_div;
    cmd_in.step = cfg_step;
  end

  // Next accumulator, direction and sample; a pending run command's settings
  // already govern the update on the tick that consumes it.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    apply_run  = pend_full_q && pend_q.run;
    apply_stop = pend_full_q && !pend_q.run;
    wave_sel   = apply_run ? pend_q.wave : wave_q;
    step_sel   = apply_run ? pend_q.step : step_q;
    restart    = apply_run && (pend_q.wave != wave_q);
    sum        = {1'b0, acc_q} + {1'b0, step_sel};
    acc_d      = acc_q;
    dir_d      = dir_q;
    data_d     = dac_data_q;
    case (wave_sel)
      WAVE_SAW: begin
        acc_d  = sum[DAC_W-1:0];
        data_d = sum[DAC_W-1:0];
      end
      WAVE_TRI: begin
        if (dir_q == DIR_UP) begin
          if (sum >= ACC_MAX_EXT) begin
            acc_d = ACC_MAX;
            dir_d = DIR_DOWN;
          end else begin
            acc_d = sum[DAC_W-1:0];
          end
        end else if (acc_q <= step_sel) begin
          acc_d = '0;
          dir_d = DIR_UP;
        end else begin
          acc_d = acc_q - step_sel;
        end
        data_d = acc_d;
      end
      WAVE_SQUARE: begin
        acc_d  = sum[DAC_W-1:0];
        data_d = {DAC_W{sum[DAC_W-1]}};
      end
      WAVE_HOLD: begin
        acc_d  = acc_q;
        data_d = dac_data_q;
      end
    endcase
    if (restart) begin
      acc_d  = '0;
      dir_d  = DIR_UP;
      data_d = '0;
    end
  end

  // FSM, pending slot and registered sample outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      wave_q       <= WAVE_SAW;
      step_q       <= '0;
      div_q        <= DIV_ONE;
      acc_q        <= '0;
      dir_q        <= DIR_UP;
      dac_data_q   <= '0;
      sample_stb_q <= 1'b0;
      pend_full_q  <= 1'b0;
      pend_q       <= '0;
    end else begin
      sample_stb_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Stop commands in IDLE are accepted and dropped.
          if (hs && cmd_in.run) begin
            wave_q     <= cmd_in.wave;
            step_q     <= cmd_in.step;
            div_q      <= cmd_in.div;
            acc_q      <= '0;
            dir_q      <= DIR_UP;
            dac_data_q <= '0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            pend_full_q <= 1'b0;
            if (apply_stop) begin
              dac_data_q <= '0;
              state_q    <= ST_IDLE;
            end else begin
              if (apply_run) begin
                wave_q <= pend_q.wave;
                step_q <= pend_q.step;
                div_q  <= pend_q.div;
              end
              acc_q        <= acc_d;
              dir_q        <= dir_d;
              dac_data_q   <= data_d;
              sample_stb_q <= 1'b1;
            end
          end
          // Slot is empty whenever hs is possible, so this never clobbers
          // a command being consumed on the same tick.
          if (hs) begin
            pend_q      <= cmd_in;
            pend_full_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_wave_sched.sv
// Self-checking bench for dac_wave_sched with a sample-sequence reference model.
module tb_dac_wave_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        cfg_run;
  logic [1:0]  cfg_wave;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_step;
  logic [7:0]  dac_data;
  logic        dac_clk;
  logic        sample_stb;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;
  int exp_s[0:299];

  dac_wave_sched #(.DAC_W(8), .DIV_W(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_run    (cfg_run),
    .cfg_wave   (cfg_wave),
    .cfg_div    (cfg_div),
    .cfg_step   (cfg_step),
    .dac_data   (dac_data),
    .dac_clk    (dac_clk),
    .sample_stb (sample_stb),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Wait until the negedge inside cycle c (cycle 1 = first cycle after handshake).
  task automatic at_cycle(input int c);
    do @(negedge sys_clk); while ((cyc - base) < c);
  endtask

  // Present a command and wait (bounded) for its handshake; base marks cycle N+1.
  task automatic send_cmd(input bit run, input int wave, input int div, input int step,
                          output bit ok);
    int n;
    cfg_run   = run;
    cfg_wave  = wave[1:0];
    cfg_div   = div[15:0];
    cfg_step  = step[7:0];
    cfg_valid = 1'b1;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: cfg_ready=%b after %0d cycles, required 1", cfg_ready, n);
      cfg_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge sys_clk);
      #1;
      cfg_valid = 1'b0;
      base = cyc - 1;
      ok = 1'b1;
    end
  endtask

  // Reference sample sequence; sample 0 is the value present right after start.
  task automatic build_samples(input int wave, input int step, input int n);
    int acc;
    bit up;
    acc = 0;
    up = 1'b1;
    exp_s[0] = 0;
    for (int k = 1; k < n; k++) begin
      case (wave)
        0: begin
          acc = (acc + step) % 256;
          exp_s[k] = acc;
        end
        1: begin
          if (up) begin
            if (acc + step >= 255) begin acc = 255; up = 1'b0; end
            else acc = acc + step;
          end else begin
            if (acc <= step) begin acc = 0; up = 1'b1; end
            else acc = acc - step;
          end
          exp_s[k] = acc;
        end
        2: begin
          acc = (acc + step) % 256;
          exp_s[k] = (acc >= 128) ? 255 : 0;
        end
        default: exp_s[k] = exp_s[k-1];
      endcase
    end
  endtask

  // Check every cycle of nsamp periods after a start handshake.
  task automatic check_stream(input int wave, input int div, input int step, input int nsamp);
    int d, p, k;
    logic [7:0] e_data;
    logic e_stb, e_clk;
    d = (div == 0) ? 1 : div;
    build_samples(wave, step, nsamp);
    for (int c = 1; c <= nsamp * (d + 1); c++) begin
      at_cycle(c);
      p = (c - 1) % (d + 1);
      k = (c - 1) / (d + 1);
      e_data = exp_s[k][7:0];
      e_stb  = (c > 1) && (p == 0);
      e_clk  = (p > d / 2);
      checks += 4;
      if (dac_data !== e_data) begin
        errors++;
        $display("FAIL stream_data w%0d d%0d s%0d c%0d: dac_data=%0d required %0d",
                 wave, div, step, c, dac_data, e_data);
      end
      if (sample_stb !== e_stb) begin
        errors++;
        $display("FAIL stream_stb w%0d d%0d s%0d c%0d: sample_stb=%b required %b",
                 wave, div, step, c, sample_stb, e_stb);
      end
      if (dac_clk !== e_clk) begin
        errors++;
        $display("FAIL stream_clk w%0d d%0d s%0d c%0d: dac_clk=%b required %b",
                 wave, div, step, c, dac_clk, e_clk);
      end
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL stream_busy c%0d: busy=%b required 1", c, busy);
      end
    end
  endtask

  // Send stop and confirm return to IDLE with quiet outputs.
  task automatic stop_and_idle();
    bit ok;
    int n;
    send_cmd(1'b0, 0, 0, 0, ok);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    checks += 4;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_busy: busy=%b after %0d cycles, required 0", busy, n);
    end
    if (dac_data !== 8'd0) begin
      errors++;
      $display("FAIL stop_data: dac_data=%0d required 0", dac_data);
    end
    if (dac_clk !== 1'b0) begin
      errors++;
      $display("FAIL stop_clk: dac_clk=%b required 0", dac_clk);
    end
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL stop_ready: cfg_ready=%b required 1", cfg_ready);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks += 5;
    if (dac_data !== 8'd0) begin
      errors++; $display("FAIL %s_data: dac_data=%0d required 0", tag, dac_data);
    end
    if (dac_clk !== 1'b0) begin
      errors++; $display("FAIL %s_clk: dac_clk=%b required 0", tag, dac_clk);
    end
    if (sample_stb !== 1'b0) begin
      errors++; $display("FAIL %s_stb: sample_stb=%b required 0", tag, sample_stb);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s_busy: busy=%b required 0", tag, busy);
    end
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready: cfg_ready=%b required 1", tag, cfg_ready);
    end
  endtask

  task automatic test_reset();
    sys_rst   = 1'b1;
    cfg_valid = 1'b0;
    cfg_run   = 1'b0;
    cfg_wave  = 2'd0;
    cfg_div   = 16'd0;
    cfg_step  = 8'd0;
    #12;
    check_idle_outputs("reset_hold");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_idle_outputs("reset_release");
  endtask

  task automatic test_saw();
    bit ok;
    send_cmd(1'b1, 0, 3, 1, ok);
    if (ok) check_stream(0, 3, 1, 260);
    stop_and_idle();
  endtask

  task automatic test_tri();
    bit ok;
    send_cmd(1'b1, 1, 1, 100, ok);
    if (ok) check_stream(1, 1, 100, 10);
    stop_and_idle();
  endtask

  task automatic test_square();
    bit ok;
    send_cmd(1'b1, 2, 0, 64, ok);
    if (ok) check_stream(2, 0, 64, 9);
    stop_and_idle();
  endtask

  task automatic test_random();
    bit ok;
    int w, d, s;
    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(0, 3);
      d = $urandom_range(0, 5);
      s = $urandom_range(0, 255);
      send_cmd(1'b1, w, d, s, ok);
      if (ok) check_stream(w, d, s, 12);
      stop_and_idle();
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: observed %0d required %0d", name, act, req);
    end
  endtask

  // Command landing on a tick is deferred one period; a second command waits.
  task automatic test_back_to_back();
    bit ok;
    send_cmd(1'b1, 0, 3, 5, ok);
    if (!ok) return;
    at_cycle(8);
    chk("b2b_pre_data", dac_data, 8'd5);
    chk("b2b_pre_ready", {7'd0, cfg_ready}, 8'd1);
    cfg_run = 1'b1; cfg_wave = 2'd1; cfg_div = 16'd3; cfg_step = 8'd5; cfg_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    cfg_wave = 2'd1; cfg_div = 16'd1; cfg_step = 8'd30;
    at_cycle(9);
    chk("b2b_c9_data", dac_data, 8'd10);
    chk("b2b_c9_ready", {7'd0, cfg_ready}, 8'd0);
    at_cycle(12);
    chk("b2b_c12_data", dac_data, 8'd10);
    chk("b2b_c12_ready", {7'd0, cfg_ready}, 8'd0);
    at_cycle(13);
    chk("b2b_c13_data", dac_data, 8'd0);
    chk("b2b_c13_stb", {7'd0, sample_stb}, 8'd1);
    chk("b2b_c13_ready", {7'd0, cfg_ready}, 8'd1);
    @(posedge sys_clk);
    #1;
    cfg_valid = 1'b0;
    at_cycle(14);
    chk("b2b_c14_ready", {7'd0, cfg_ready}, 8'd0);
    at_cycle(16);
    chk("b2b_c16_data", dac_data, 8'd0);
    at_cycle(17);
    chk("b2b_c17_data", dac_data, 8'd30);
    chk("b2b_c17_stb", {7'd0, sample_stb}, 8'd1);
    chk("b2b_c17_ready", {7'd0, cfg_ready}, 8'd1);
    chk("b2b_c17_clk", {7'd0, dac_clk}, 8'd0);
    at_cycle(18);
    chk("b2b_c18_clk", {7'd0, dac_clk}, 8'd1);
    at_cycle(19);
    chk("b2b_c19_data", dac_data, 8'd60);
    chk("b2b_c19_stb", {7'd0, sample_stb}, 8'd1);
    stop_and_idle();
  endtask

  task automatic test_stop();
    bit ok;
    send_cmd(1'b0, 2, 4, 9, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check_idle_outputs("idle_stop");
    end
    send_cmd(1'b1, 0, 5, 3, ok);
    if (!ok) return;
    at_cycle(8);
    chk("stop_c8_data", dac_data, 8'd3);
    at_cycle(9);
    cfg_run = 1'b0; cfg_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    cfg_valid = 1'b0;
    at_cycle(10);
    chk("stop_c10_ready", {7'd0, cfg_ready}, 8'd0);
    chk("stop_c10_busy", {7'd0, busy}, 8'd1);
    at_cycle(12);
    chk("stop_c12_data", dac_data, 8'd3);
    chk("stop_c12_clk", {7'd0, dac_clk}, 8'd1);
    chk("stop_c12_busy", {7'd0, busy}, 8'd1);
    at_cycle(13);
    check_idle_outputs("stop_c13");
    at_cycle(16);
    check_idle_outputs("stop_c16");
  endtask

  task automatic test_reset_mid();
    bit ok;
    send_cmd(1'b1, 0, 3, 1, ok);
    if (!ok) return;
    at_cycle(7);
    chk("rstmid_pre_clk", {7'd0, dac_clk}, 8'd1);
    chk("rstmid_pre_data", dac_data, 8'd1);
    sys_rst = 1'b1;
    #1;
    check_idle_outputs("rstmid_async");
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check_idle_outputs("rstmid_after");
    end
    send_cmd(1'b1, 0, 3, 1, ok);
    if (ok) check_stream(0, 3, 1, 5);
    stop_and_idle();
  endtask

  initial begin
    test_reset();
    test_saw();
    test_tri();
    test_square();
    test_back_to_back();
    test_stop();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
